rr_mux8_arbiter: RTL and testbench
==================================

RR_MUX8_ARBITER -- requirements
Module: rr_mux8_arbiter

Interface
REQ-001 Parameter W, default 8, SHALL set the data width of each of the 8 channels and of the output.
REQ-002 Parameter PRIO_MODE, default 0, SHALL select the arbitration mode: 0 = round-robin, 1 = fixed priority with channel 0 highest.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  8  per-channel request; req[i]=1 means data[i] is valid.
REQ-006 data  input  8*W  channel data; channel i occupies bits [i*W +: W].
REQ-007 ack  output  8  one-hot capture strobe back to the requesters.
REQ-008 out  output  W  registered selected data.
REQ-009 out_valid  output  1  out holds an unconsumed word.
REQ-010 out_ready  input  1  downstream accepts out when out_valid=1.
REQ-011 sel  output  3  index of the channel currently held in out.
REQ-012 busy  output  1  equals out_valid.

Function
REQ-013 The block SHALL implement an 8:1 selection of data onto out, sharing the output between up to 8 requesters.
REQ-014 Two states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-015 load SHALL be defined as (state==IDLE or (out_valid and out_ready)) and (req != 0).
REQ-016 When load=1 the winner SHALL be chosen combinationally: PRIO_MODE=0 selects the first set req bit scanning upward from ptr with wrap 7->0; PRIO_MODE=1 selects the lowest set req bit.
REQ-017 In the load cycle ack SHALL be the one-hot code of the winner (a Mealy output); otherwise ack=0; ack SHALL never have more than one bit set.
REQ-018 On the edge ending a load cycle: out <= data[winner], sel <= winner, out_valid <= 1, ptr <= (winner+1) mod 8; state becomes HOLD.
REQ-019 In HOLD with out_ready=0, out, sel and out_valid SHALL stay stable regardless of req changes, and ack=0.
REQ-020 In HOLD with out_ready=1 and req=0, out_valid SHALL go 0 next cycle and state SHALL return to IDLE; out and sel SHALL retain their last values.
REQ-021 In HOLD with out_ready=1 and req!=0, a new winner SHALL be loaded in the same cycle (back-to-back), sustaining one word per cycle.
REQ-022 Latency: a req rising in IDLE SHALL give ack in the same cycle and out_valid=1 on the next edge.
REQ-023 In round-robin mode, a continuously asserted req[i] SHALL be granted within 8 loads (no starvation).
REQ-024 ptr SHALL be a 3-bit register wrapping modulo 8; PRIO_MODE=1 SHALL ignore ptr.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 A requester SHALL treat ack[i] as consumption of data[i] at that edge; the block SHALL capture each acked word exactly once.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge, force out=0, sel=0, out_valid=0, ptr=0 and state IDLE; ack SHALL be 0 while rst_n=0.
REQ-028 Reset asserted during HOLD SHALL discard the held word; the first load after reset SHALL begin scanning at channel 0.
REQ-029 The first rising clk edge after rst_n deasserts SHALL be able to perform a load.

Verification
REQ-030 Reset, then req=8'hFF with out_ready=1 held for 9 cycles -> ack = 01,02,04,...,80,01 on successive cycles; sel = 0..7,0; out_valid=1 continuously.
REQ-031 req=8'h08, data[3]=8'hA5, out_ready=0 for 5 cycles -> one ack=8'h08 pulse; out=A5, sel=3 and out_valid=1 stable for 5 cycles; out_valid=0 one cycle after out_ready=1 once req=0.
REQ-032 Last grant channel 7 (ptr=0), then req=8'h41 -> grant 0; next load with req still 8'h41 -> grant 6.
REQ-033 PRIO_MODE=1, req=8'hA2 held, out_ready=1 -> ack=8'h02 and sel=1 on every cycle.
REQ-034 rst_n pulsed low mid-HOLD with out=8'h3C -> out=0, out_valid=0, ack=0 immediately; after release with req=8'h80 -> ack=8'h80 and out=data[7] next edge.
REQ-035 Random req, data and out_ready for 10k cycles -> scoreboard checks that every acked word appears on out exactly once, in ack order, that ack is never more than one-hot, and that no channel waits more than 8 loads.

Source files
------------

// File: rtl/rr_mux8_arbiter_if.sv
// Bus bundle for the 8-channel round-robin output mux: requester side
// (req/data/ack) plus the downstream valid/ready output port.
interface rr_mux8_arbiter_if #(
  parameter int W = 8
);
  logic [7:0]     req;
  logic [8*W-1:0] data;
  logic [7:0]     ack;
  logic [W-1:0]   out;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     sel;
  logic           busy;

  modport slave (
    input  req, data, out_ready,
    output ack, out, out_valid, sel, busy
  );

  modport master (
    output req, data, out_ready,
    input  ack, out, out_valid, sel, busy
  );
endinterface

// File: rtl/rr_mux8_arbiter.sv
// 8:1 arbitrated mux with a one-word registered output stage. The winner is
// acked in the load cycle; round-robin or fixed-priority selection.
module rr_mux8_arbiter #(
  parameter int W         = 8,
  parameter int PRIO_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_mux8_arbiter_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t         state_r, state_nxt_s;
  logic [2:0]     ptr_r, ptr_nxt_s;
  logic [2:0]     sel_r, sel_nxt_s;
  logic [W-1:0]   out_r, out_nxt_s;
  logic [2:0]     win_s, idx_s;
  logic           found_s;
  logic           load_s;
  logic [7:0]     ack_s;
  logic [W-1:0]   chan_s [8];

  // Unpack the flat data bus into per-channel words
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      chan_s[i] = bus.data[i*W +: W];
    end
  end

  // Winner search: scan upward from ptr (round-robin) or from 0 (priority)
  always_comb begin
    win_s   = 3'd0;
    idx_s   = 3'd0;
    found_s = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (PRIO_MODE == 1) begin
        idx_s = k[2:0];
      end else begin
        idx_s = ptr_r + k[2:0];
      end
      if (bus.req[idx_s] && !found_s) begin
        win_s   = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Load condition and Mealy ack; ack is forced low while reset is asserted
  always_comb begin
    load_s = ((state_r == IDLE) || ((state_r == HOLD) && bus.out_ready))
             && (bus.req != 8'd0);
    if (load_s && rst_n) begin
      ack_s = 8'd1 << win_s;
    end else begin
      ack_s = 8'd0;
    end
  end

  // Next-state and next-output logic for the IDLE/HOLD output stage
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    sel_nxt_s   = sel_r;
    out_nxt_s   = out_r;
    case (state_r)
      IDLE: begin
        if (load_s) begin
          state_nxt_s = HOLD;
          ptr_nxt_s   = win_s + 3'd1;
          sel_nxt_s   = win_s;
          out_nxt_s   = chan_s[win_s];
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        if (load_s) begin
          state_nxt_s = HOLD;
          ptr_nxt_s   = win_s + 3'd1;
          sel_nxt_s   = win_s;
          out_nxt_s   = chan_s[win_s];
        end else if (bus.out_ready) begin
          // Drained with nothing waiting: out/sel keep their last values
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, pointer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 3'd0;
      sel_r   <= 3'd0;
      out_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      sel_r   <= sel_nxt_s;
      out_r   <= out_nxt_s;
    end
  end

  assign bus.ack       = ack_s;
  assign bus.out       = out_r;
  assign bus.sel       = sel_r;
  assign bus.out_valid = (state_r == HOLD);
  assign bus.busy      = (state_r == HOLD);

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed vector table plus corner sequences and a randomised scoreboard
// run for rr_mux8_arbiter (round-robin instance, plus a priority instance).
module tb_rr_mux8_arbiter;

  logic clk;
  logic rst_n;
  logic [7:0] chan_data [8];
  int checks;
  int errors;

  rr_mux8_arbiter_if #(.W(8)) bus ();
  rr_mux8_arbiter_if #(.W(8)) bus_p ();

  rr_mux8_arbiter #(.W(8), .PRIO_MODE(0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  rr_mux8_arbiter #(.W(8), .PRIO_MODE(1)) dut_p (.clk(clk), .rst_n(rst_n), .bus(bus_p));

  for (genvar g = 0; g < 8; g++) begin : g_data
    assign bus.data[g*8 +: 8]   = chan_data[g];
    assign bus_p.data[g*8 +: 8] = chan_data[g];
  end
  assign bus_p.req       = bus.req;
  assign bus_p.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic [7:0] ack;
    logic       vld;
    logic [2:0] sel;
    logic [7:0] out;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] r, input logic y, input logic [7:0] a,
                              input logic v, input logic [2:0] s, input logic [7:0] o);
    vec_t t;
    t.req = r; t.rdy = y; t.ack = a; t.vld = v; t.sel = s; t.out = o;
    return t;
  endfunction

  task automatic set_default_data();
    chan_data[0] = 8'h5A; chan_data[1] = 8'h61; chan_data[2] = 8'h72; chan_data[3] = 8'hA5;
    chan_data[4] = 8'h84; chan_data[5] = 8'h95; chan_data[6] = 8'h36; chan_data[7] = 8'hE7;
  endtask

  initial begin
    logic [7:0] dflt [8];
    logic [2:0] m_ptr, m_sel, w, idx;
    logic       m_valid, ld, found;
    logic [7:0] reqv, exp_ack, m_out;
    logic [7:0] sb[$];
    int         waitc [8];

    checks = 0;
    errors = 0;
    set_default_data();
    for (int i = 0; i < 8; i++) dflt[i] = chan_data[i];
    rst_n = 1'b0;
    bus.req = 8'hFF;
    bus.out_ready = 1'b0;

    // Reset state, with ack gated even though requests are pending
    #12;
    chk("rst_ack", bus.ack, 8'h00);
    chk("rst_vld", bus.out_valid, 1'b0);
    chk("rst_out", bus.out, 8'h00);
    chk("rst_sel", bus.sel, 3'd0);
    chk("rst_busy", bus.busy, 1'b0);
    bus.req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Round-robin sweep with everybody requesting and ready held high
    for (int k = 0; k < 9; k++) begin
      tbl.push_back(mk(8'hFF, 1'b1, 8'd1 << (k % 8), 1'b1, 3'(k % 8), dflt[k % 8]));
    end
    tbl.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h5A));
    // Single request stalled downstream, then drained
    tbl.push_back(mk(8'h08, 1'b0, 8'h08, 1'b1, 3'd3, 8'hA5));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(8'h08, 1'b0, 8'h00, 1'b1, 3'd3, 8'hA5));
    tbl.push_back(mk(8'hFF, 1'b0, 8'h00, 1'b1, 3'd3, 8'hA5));
    tbl.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0, 3'd3, 8'hA5));
    tbl.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0, 3'd3, 8'hA5));
    // Pointer wrap after channel 7
    tbl.push_back(mk(8'h80, 1'b1, 8'h80, 1'b1, 3'd7, 8'hE7));
    tbl.push_back(mk(8'h41, 1'b1, 8'h01, 1'b1, 3'd0, 8'h5A));
    tbl.push_back(mk(8'h41, 1'b0, 8'h00, 1'b1, 3'd0, 8'h5A));
    tbl.push_back(mk(8'h41, 1'b1, 8'h40, 1'b1, 3'd6, 8'h36));
    tbl.push_back(mk(8'h41, 1'b1, 8'h01, 1'b1, 3'd0, 8'h5A));
    tbl.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 8'h5A));

    for (int i = 0; i < tbl.size(); i++) begin
      bus.req = tbl[i].req;
      bus.out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_ack", i), bus.ack, tbl[i].ack);
      @(posedge clk); #1;
      chk($sformatf("v%0d_vld", i), bus.out_valid, tbl[i].vld);
      chk($sformatf("v%0d_busy", i), bus.busy, tbl[i].vld);
      chk($sformatf("v%0d_sel", i), bus.sel, tbl[i].sel);
      chk($sformatf("v%0d_out", i), bus.out, tbl[i].out);
    end

    // Fixed-priority instance always picks channel 1 out of 8'hA2
    for (int k = 0; k < 4; k++) begin
      bus.req = 8'hA2;
      bus.out_ready = 1'b1;
      #1;
      chk("prio_ack", bus_p.ack, 8'h02);
      @(posedge clk); #1;
      chk("prio_sel", bus_p.sel, 3'd1);
      chk("prio_out", bus_p.out, 8'h61);
      chk("prio_vld", bus_p.out_valid, 1'b1);
    end
    bus.req = 8'h00;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a held word
    chan_data[2] = 8'h3C;
    bus.req = 8'h04;
    bus.out_ready = 1'b0;
    #1;
    chk("hold_ack", bus.ack, 8'h04);
    @(posedge clk); #1;
    chk("hold_out", bus.out, 8'h3C);
    chk("hold_vld", bus.out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", bus.out, 8'h00);
    chk("arst_vld", bus.out_valid, 1'b0);
    chk("arst_sel", bus.sel, 3'd0);
    chk("arst_ack", bus.ack, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    chan_data[2] = 8'h72;
    bus.req = 8'h80;
    #1;
    chk("post_rst_ack", bus.ack, 8'h80);
    @(posedge clk); #1;
    chk("post_rst_out", bus.out, 8'hE7);
    chk("post_rst_sel", bus.sel, 3'd7);
    chk("post_rst_vld", bus.out_valid, 1'b1);

    // Reset must also return the scan pointer to channel 0
    bus.req = 8'h04;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst2_sel", bus.sel, 3'd2);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 8'h81;
    #1;
    chk("rst_ptr_ack", bus.ack, 8'h01);
    @(posedge clk); #1;
    chk("rst_ptr_sel", bus.sel, 3'd0);

    // Randomised run against a reference model and scoreboard
    bus.req = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_ptr = 3'd0; m_sel = 3'd0; m_valid = 1'b0; m_out = 8'h00;
    exp_ack = 8'h00;
    reqv = 8'h00;
    for (int i = 0; i < 8; i++) waitc[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (reqv[i] && !exp_ack[i]) reqv[i] = 1'b1;
        else reqv[i] = ($urandom_range(0, 3) == 0);
        chan_data[i] = 8'($urandom);
      end
      bus.req = reqv;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ld = (!m_valid || bus.out_ready) && (reqv != 8'h00);
      w = 3'd0;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        idx = m_ptr + 3'(k);
        if (reqv[idx] && !found) begin
          w = idx;
          found = 1'b1;
        end
      end
      exp_ack = ld ? (8'd1 << w) : 8'h00;
      chk("rnd_ack", bus.ack, exp_ack);
      chk("rnd_onehot", ($countones(bus.ack) <= 1), 1'b1);
      if (ld) begin
        sb.push_back(chan_data[w]);
        for (int i = 0; i < 8; i++) begin
          if (reqv[i] && (3'(i) != w)) begin
            waitc[i]++;
            chk($sformatf("rnd_starve%0d", i), (waitc[i] <= 7), 1'b1);
          end else begin
            waitc[i] = 0;
          end
        end
        m_valid = 1'b1;
        m_sel = w;
        m_ptr = w + 3'd1;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (ld) begin
        m_out = sb.pop_front();
        chk("rnd_out", bus.out, m_out);
      end
      chk("rnd_vld", bus.out_valid, m_valid);
      chk("rnd_sel", bus.sel, m_sel);
      chk("rnd_hold", bus.out, m_out);
    end
    chk("rnd_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
